// File: rtl/csr_file.sv
// Machine-mode CSR register file serving the ex and clint write/read ports.
// Optional feature: define CSR_MCYCLE_EN to add the 64-bit mcycle counter
// (0xB00 low half, 0xB80 high half).
module csr_file #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_we_i,
    input  logic [31:0] ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [31:0] id_raddr_i,
    output logic [31:0] id_rdata_o,
    input  logic        clint_we_i,
    input  logic [31:0] clint_waddr_i,
    input  logic [31:0] clint_wdata_i,
    input  logic [31:0] clint_raddr_i,
    output logic [31:0] clint_rdata_o,
    output logic [31:0] csr_mtvec_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mstatus_o,
    output logic        global_int_en_o
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned AW     = 12;
    localparam int unsigned MIE_BIT = 3;

    localparam logic [AW-1:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [AW-1:0] ADDR_MIE      = 12'h304;
    localparam logic [AW-1:0] ADDR_MTVEC    = 12'h305;
    localparam logic [AW-1:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [AW-1:0] ADDR_MEPC     = 12'h341;
    localparam logic [AW-1:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [AW-1:0] ADDR_MIP      = 12'h344;
`ifdef CSR_MCYCLE_EN
    localparam logic [AW-1:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [AW-1:0] ADDR_MCYCLEH  = 12'hB80;
`endif

    logic [AW-1:0]   ex_wa;
    logic [AW-1:0]   clint_wa;
    logic [AW-1:0]   id_ra;
    logic [AW-1:0]   clint_ra;

    logic [XLEN-1:0] mstatus_q;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
`ifdef CSR_MCYCLE_EN
    logic [XLEN-1:0] mcycle_lo_q;
    logic [XLEN-1:0] mcycle_hi_q;
`endif

    // Only the low 12 address bits select a CSR; the rest are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ex_waddr_i[31:AW], clint_waddr_i[31:AW],
                                id_raddr_i[31:AW], clint_raddr_i[31:AW]};

    assign ex_wa    = ex_waddr_i[AW-1:0];
    assign clint_wa = clint_waddr_i[AW-1:0];
    assign id_ra    = id_raddr_i[AW-1:0];
    assign clint_ra = clint_raddr_i[AW-1:0];

    function automatic logic ex_hit(input logic [AW-1:0] a);
        return ex_we_i && (ex_wa == a);
    endfunction

    function automatic logic clint_hit(input logic [AW-1:0] a);
        return clint_we_i && (clint_wa == a);
    endfunction

    // Addresses that accept writes (and therefore forward write data to reads).
    function automatic logic is_writable(input logic [AW-1:0] a);
        logic w;
        w = 1'b0;
        case (a)
            ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC,
            ADDR_MSCRATCH, ADDR_MEPC, ADDR_MCAUSE: w = 1'b1;
`ifdef CSR_MCYCLE_EN
            ADDR_MCYCLE, ADDR_MCYCLEH:             w = 1'b1;
`endif
            default:                               w = 1'b0;
        endcase
        return w;
    endfunction

    // Read mux with same-cycle write forwarding; clint data has priority.
    function automatic logic [XLEN-1:0] csr_read(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        case (a)
            ADDR_MSTATUS:  v = mstatus_q;
            ADDR_MIE:      v = mie_q;
            ADDR_MTVEC:    v = mtvec_q;
            ADDR_MSCRATCH: v = mscratch_q;
            ADDR_MEPC:     v = mepc_q;
            ADDR_MCAUSE:   v = mcause_q;
            ADDR_MIP:      v = '0;
`ifdef CSR_MCYCLE_EN
            ADDR_MCYCLE:   v = mcycle_lo_q;
            ADDR_MCYCLEH:  v = mcycle_hi_q;
`endif
            default:       v = '0;
        endcase
        if (is_writable(a)) begin
            if (clint_hit(a)) begin
                v = clint_wdata_i;
            end else if (ex_hit(a)) begin
                v = ex_wdata_i;
            end
        end
        return v;
    endfunction

    // Zero-latency read ports.
    always_comb begin
        id_rdata_o    = csr_read(id_ra);
        clint_rdata_o = csr_read(clint_ra);
    end

    // CSR storage; clint wins when both ports write the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q  <= '0;
            mie_q      <= '0;
            mtvec_q    <= RESET_MTVEC;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            if (clint_hit(ADDR_MSTATUS))       mstatus_q  <= clint_wdata_i;
            else if (ex_hit(ADDR_MSTATUS))     mstatus_q  <= ex_wdata_i;

            if (clint_hit(ADDR_MIE))           mie_q      <= clint_wdata_i;
            else if (ex_hit(ADDR_MIE))         mie_q      <= ex_wdata_i;

            if (clint_hit(ADDR_MTVEC))         mtvec_q    <= clint_wdata_i;
            else if (ex_hit(ADDR_MTVEC))       mtvec_q    <= ex_wdata_i;

            if (clint_hit(ADDR_MSCRATCH))      mscratch_q <= clint_wdata_i;
            else if (ex_hit(ADDR_MSCRATCH))    mscratch_q <= ex_wdata_i;

            if (clint_hit(ADDR_MEPC))          mepc_q     <= clint_wdata_i;
            else if (ex_hit(ADDR_MEPC))        mepc_q     <= ex_wdata_i;

            if (clint_hit(ADDR_MCAUSE))        mcause_q   <= clint_wdata_i;
            else if (ex_hit(ADDR_MCAUSE))      mcause_q   <= ex_wdata_i;
        end
    end

`ifdef CSR_MCYCLE_EN
    // Free-running cycle counter; a written half loads, the other keeps counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_lo_q <= '0;
            mcycle_hi_q <= '0;
        end else begin
            if (clint_hit(ADDR_MCYCLE))        mcycle_lo_q <= clint_wdata_i;
            else if (ex_hit(ADDR_MCYCLE))      mcycle_lo_q <= ex_wdata_i;
            else                               mcycle_lo_q <= mcycle_lo_q + XLEN'(1);

            if (clint_hit(ADDR_MCYCLEH))       mcycle_hi_q <= clint_wdata_i;
            else if (ex_hit(ADDR_MCYCLEH))     mcycle_hi_q <= ex_wdata_i;
            else if (&mcycle_lo_q)             mcycle_hi_q <= mcycle_hi_q + XLEN'(1);
        end
    end
`endif

    // Register views for clint; no forwarding here.
    always_comb begin
        csr_mtvec_o     = mtvec_q;
        csr_mepc_o      = mepc_q;
        csr_mstatus_o   = mstatus_q;
        global_int_en_o = mstatus_q[MIE_BIT];
    end

endmodule

// File: tb/tb_csr_file.sv
// Randomized + directed bench for csr_file against an address-map reference model.
module tb_csr_file;

    localparam logic [31:0] TB_MTVEC = 32'h8000_0100;
`ifdef CSR_MCYCLE_EN
    localparam bit HAS_MCYCLE = 1'b1;
`else
    localparam bit HAS_MCYCLE = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        ex_we_i;
    logic [31:0] ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic [31:0] id_raddr_i;
    logic [31:0] id_rdata_o;
    logic        clint_we_i;
    logic [31:0] clint_waddr_i;
    logic [31:0] clint_wdata_i;
    logic [31:0] clint_raddr_i;
    logic [31:0] clint_rdata_o;
    logic [31:0] csr_mtvec_o;
    logic [31:0] csr_mepc_o;
    logic [31:0] csr_mstatus_o;
    logic        global_int_en_o;

    csr_file #(.RESET_MTVEC(TB_MTVEC)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_we_i         (ex_we_i),
        .ex_waddr_i      (ex_waddr_i),
        .ex_wdata_i      (ex_wdata_i),
        .id_raddr_i      (id_raddr_i),
        .id_rdata_o      (id_rdata_o),
        .clint_we_i      (clint_we_i),
        .clint_waddr_i   (clint_waddr_i),
        .clint_wdata_i   (clint_wdata_i),
        .clint_raddr_i   (clint_raddr_i),
        .clint_rdata_o   (clint_rdata_o),
        .csr_mtvec_o     (csr_mtvec_o),
        .csr_mepc_o      (csr_mepc_o),
        .csr_mstatus_o   (csr_mstatus_o),
        .global_int_en_o (global_int_en_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: plain address map plus a 64-bit cycle count.
    logic [31:0] mreg [int];
    logic [63:0] m_cnt;
    logic [63:0] m_nxt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit writable(input logic [11:0] a);
        if (a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342}) return 1'b1;
        if (HAS_MCYCLE && (a inside {12'hB00, 12'hB80})) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] stored(input logic [11:0] a);
        if (!writable(a)) return 32'h0;
        if (a == 12'hB00) return m_cnt[31:0];
        if (a == 12'hB80) return m_cnt[63:32];
        return mreg[int'(a)];
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] addr);
        logic [11:0] a;
        a = addr[11:0];
        if (clint_we_i && clint_waddr_i[11:0] == a && writable(a)) return clint_wdata_i;
        if (ex_we_i && ex_waddr_i[11:0] == a && writable(a)) return ex_wdata_i;
        return stored(a);
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] d);
        logic [11:0] a;
        a = addr[11:0];
        if (writable(a)) begin
            if (a == 12'hB00)      m_nxt[31:0]  = d;
            else if (a == 12'hB80) m_nxt[63:32] = d;
            else                   mreg[int'(a)] = d;
        end
    endtask

    task automatic model_step();
        if (rst) begin
            mreg[12'h300] = 32'h0;
            mreg[12'h304] = 32'h0;
            mreg[12'h305] = TB_MTVEC;
            mreg[12'h340] = 32'h0;
            mreg[12'h341] = 32'h0;
            mreg[12'h342] = 32'h0;
            m_cnt = 64'h0;
        end else begin
            m_nxt = m_cnt + 64'd1;
            if (ex_we_i)    model_write(ex_waddr_i, ex_wdata_i);
            if (clint_we_i) model_write(clint_waddr_i, clint_wdata_i);
            m_cnt = m_nxt;
        end
    endtask

    // One clock: drive at negedge, check just after, advance model at posedge.
    task automatic cycle(input logic ewe, input logic [31:0] ea, input logic [31:0] ed,
                         input logic cwe, input logic [31:0] ca, input logic [31:0] cd,
                         input logic [31:0] ira, input logic [31:0] cra);
        logic [31:0] ms;
        @(negedge clk);
        ex_we_i       = ewe;
        ex_waddr_i    = ea;
        ex_wdata_i    = ed;
        clint_we_i    = cwe;
        clint_waddr_i = ca;
        clint_wdata_i = cd;
        id_raddr_i    = ira;
        clint_raddr_i = cra;
        #1;
        if (!rst) begin
            ms = stored(12'h300);
            chk("id_rdata",    id_rdata_o,    exp_read(ira));
            chk("clint_rdata", clint_rdata_o, exp_read(cra));
            chk("mtvec_o",     csr_mtvec_o,   stored(12'h305));
            chk("mepc_o",      csr_mepc_o,    stored(12'h341));
            chk("mstatus_o",   csr_mstatus_o, ms);
            chk("gie_o",       {31'h0, global_int_en_o}, {31'h0, ms[3]});
        end
        @(posedge clk);
        model_step();
        #1;
        ex_we_i    = 1'b0;
        clint_we_i = 1'b0;
    endtask

    task automatic idle(input logic [31:0] ira, input logic [31:0] cra);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, ira, cra);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [11:0] pool [12];
        logic [31:0] a;
        pool = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                 12'h344, 12'h7C0, 12'hB00, 12'hB80, 12'hF14, 12'h300};
        a = {20'h0, pool[$urandom_range(0, 11)]};
        if ($urandom_range(0, 3) == 0) a[31:12] = 20'($urandom);
        return a;
    endfunction

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'hFFFF_FFFD;
            2:       return 32'h0000_0008;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        m_cnt = 64'h0;
        m_nxt = 64'h0;
        ex_we_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0; id_raddr_i = '0;
        clint_we_i = 1'b0; clint_waddr_i = '0; clint_wdata_i = '0; clint_raddr_i = '0;

        rst = 1'b1;
        idle(32'h300, 32'h305);
        idle(32'h300, 32'h305);
        rst = 1'b0;

        // Reset state.
        chk("rst_mtvec",   csr_mtvec_o,   TB_MTVEC);
        chk("rst_mepc",    csr_mepc_o,    32'h0);
        chk("rst_mstatus", csr_mstatus_o, 32'h0);
        chk("rst_gie",     {31'h0, global_int_en_o}, 32'h0);
        chk("rst_rd300",   id_rdata_o,    32'h0);
        idle(32'h342, 32'h305);
        chk("rst_mcause",  id_rdata_o,    32'h0);

        // mtvec write with forwarding in the write cycle.
        cycle(1'b1, 32'h305, 32'h100, 1'b0, 32'h0, 32'h0, 32'h305, 32'h305);
        chk("mtvec_upd", csr_mtvec_o, 32'h100);

        // MIE set by ex, then clint trap entry sequence.
        cycle(1'b1, 32'h300, 32'h8, 1'b0, 32'h0, 32'h0, 32'h300, 32'h300);
        chk("gie_set", {31'h0, global_int_en_o}, 32'h1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h341, 32'h40, 32'h341, 32'h300);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h300, 32'h0, 32'h341, 32'h300);
        chk("gie_clr", {31'h0, global_int_en_o}, 32'h0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h342, 32'h8000_0004, 32'h342, 32'h341);
        chk("trap_mepc",   csr_mepc_o, 32'h40);
        chk("trap_mcause", id_rdata_o, 32'h8000_0004);

        // Same-address collision: clint wins. Different addresses: both land.
        cycle(1'b1, 32'h341, 32'h11, 1'b1, 32'h341, 32'h22, 32'h341, 32'h341);
        chk("collide_mepc", csr_mepc_o, 32'h22);
        cycle(1'b1, 32'h340, 32'hAA, 1'b1, 32'h304, 32'hBB, 32'h340, 32'h304);
        chk("dual_mscratch", id_rdata_o,    32'hAA);
        chk("dual_mie",      clint_rdata_o, 32'hBB);

        // Dropped writes and address aliasing.
        cycle(1'b1, 32'h7C0, 32'hFFFF_FFFF, 1'b1, 32'h344, 32'hFFFF_FFFF, 32'h7C0, 32'h344);
        chk("drop_7c0", id_rdata_o,    32'h0);
        chk("drop_mip", clint_rdata_o, 32'h0);
        cycle(1'b1, 32'h1300, 32'h88, 1'b0, 32'h0, 32'h0, 32'h300, 32'h1300);
        chk("alias_mstatus", csr_mstatus_o, 32'h88);
        chk("alias_gie", {31'h0, global_int_en_o}, 32'h1);

        // Cycle counter carry, or its absence.
        cycle(1'b1, 32'hB00, 32'hFFFF_FFFE, 1'b1, 32'hB80, 32'h0, 32'hB00, 32'hB80);
        idle(32'hB00, 32'hB80);
        idle(32'hB00, 32'hB80);
        chk("mcycle_lo", id_rdata_o,    32'h0);
        chk("mcycle_hi", clint_rdata_o, HAS_MCYCLE ? 32'h1 : 32'h0);

        // Reset overrides a coincident write.
        rst = 1'b1;
        cycle(1'b1, 32'h305, 32'h55, 1'b1, 32'h300, 32'h8, 32'h305, 32'h300);
        rst = 1'b0;
        chk("rstwr_mtvec",   csr_mtvec_o,   TB_MTVEC);
        chk("rstwr_mstatus", csr_mstatus_o, 32'h0);

        // Randomized traffic with frequent address collisions and rare resets.
        for (int i = 0; i < 800; i++) begin
            logic [31:0] ea;
            logic [31:0] ca;
            logic [31:0] ira;
            ea = rand_addr();
            ca = ($urandom_range(0, 2) == 0) ? ea : rand_addr();
            ira = ($urandom_range(0, 1) == 0) ? ea : rand_addr();
            rst = ($urandom_range(0, 79) == 0);
            cycle(1'($urandom), ea, rand_data(), 1'($urandom), ca, rand_data(), ira, ca);
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
